// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU execute unit: operation encodings,
// FSM state encoding and the default datapath width.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] ALU_SUM = 3'b000;
    localparam logic [2:0] ALU_SLT = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Unknown encodings fall to the default arm so they are treated as non-shift ops.
    function automatic logic is_shift_op(input logic [2:0] op);
        case (op)
            ALU_SRA, ALU_SLL, ALU_SRL: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: loads an operand and shift count, then moves one bit
// position per cycle; data_out is the value after the current cycle's shift.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int  XLEN    = XLEN_DEFAULT,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [2:0]         op,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [XLEN-1:0]    data_in,
    output logic [XLEN-1:0]    data_out,
    output logic               last
);

    logic [XLEN-1:0]    shreg;
    logic [SHAMT_W-1:0] cnt;
    logic [2:0]         op_q;

    always_comb begin
        case (op_q)
            ALU_SLL: data_out = {shreg[XLEN-2:0], 1'b0};
            ALU_SRA: data_out = {shreg[XLEN-1], shreg[XLEN-1:1]};
            default: data_out = {1'b0, shreg[XLEN-1:1]};
        endcase
    end

    assign last = (cnt == SHAMT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            op_q  <= ALU_SUM;
        end else if (load) begin
            shreg <= data_in;
            cnt   <= shamt;
            op_q  <= op;
        end else if (cnt != '0) begin
            shreg <= data_out;
            cnt   <= cnt - SHAMT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc_exec.sv
// Multi-cycle integer execute unit with valid/ready on both sides.
// Define ALU_MC_BARREL_SHIFT_EN to replace the bit-serial shifter with a one-cycle barrel shift.
module alu_mc_exec
    import alu_pkg::*;
#(
    parameter int  XLEN    = XLEN_DEFAULT,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ALUControl,
    input  logic            sub,
    input  logic            cmp_unsigned,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    state_t             state;
    logic               accept;
    logic               start_shift;
    logic               lt;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_out;
    logic [XLEN-1:0]    sh_out;
    logic               sh_last;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHAMT_W-1:0];
    assign lt       = cmp_unsigned ? (a < b) : ($signed(a) < $signed(b));

    // Shifts by zero land in the default arm and simply pass a through.
    always_comb begin
        case (ALUControl)
            ALU_SUM: alu_out = a + (sub ? ~b : b) + {{(XLEN-1){1'b0}}, sub};
            ALU_SLT: alu_out = {{(XLEN-1){1'b0}}, lt};
            ALU_AND: alu_out = a & b;
            ALU_OR:  alu_out = a | b;
            ALU_XOR: alu_out = a ^ b;
`ifdef ALU_MC_BARREL_SHIFT_EN
            ALU_SRA: alu_out = $signed(a) >>> shamt;
            ALU_SLL: alu_out = a << shamt;
            ALU_SRL: alu_out = a >> shamt;
`endif
            default: alu_out = a;
        endcase
    end

`ifdef ALU_MC_BARREL_SHIFT_EN
    assign start_shift = 1'b0;
    assign sh_out      = '0;
    assign sh_last     = 1'b0;
`else
    assign start_shift = accept && is_shift_op(ALUControl) && (shamt != '0);

    alu_serial_shifter #(.XLEN(XLEN)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_shift_op(ALUControl)),
        .op       (ALUControl),
        .shamt    (shamt),
        .data_in  (a),
        .data_out (sh_out),
        .last     (sh_last)
    );
`endif

    // A new accept takes priority over the DONE->IDLE release, giving bubble-free issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else if (accept) begin
            busy <= 1'b1;
            if (start_shift) begin
                state     <= SHIFT;
                out_valid <= 1'b0;
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                result    <= alu_out;
                zero      <= (alu_out == '0);
            end
        end else begin
            case (state)
                SHIFT: begin
                    if (sh_last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= sh_out;
                        zero      <= (sh_out == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc_exec.sv
// Self-checking bench for alu_mc_exec: directed cases plus randomized traffic
// compared against an arithmetic reference model.
module tb_alu_mc_exec;

    localparam logic [2:0] OP_SUM = 3'b000;
    localparam logic [2:0] OP_SLT = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ALUControl;
    logic        sub;
    logic        cmp_unsigned;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_mc_exec #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ALUControl   (ALUControl),
        .sub          (sub),
        .cmp_unsigned (cmp_unsigned),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the architectural meaning of each op.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic sb, input logic cu,
                                             input logic [31:0] av, input logic [31:0] bv);
        longint unsigned s;
        int sa, sbv, sh;
        sa  = av;
        sbv = bv;
        sh  = int'(bv % 32);
        case (op)
            OP_SUM: begin
                s = sb ? (longint'(av) + 64'h1_0000_0000 - longint'(bv)) : (longint'(av) + longint'(bv));
                return s[31:0];
            end
            OP_SLT: return cu ? ((av < bv) ? 32'd1 : 32'd0) : ((sa < sbv) ? 32'd1 : 32'd0);
            OP_AND: return av & bv;
            OP_OR:  return av | bv;
            OP_XOR: return av ^ bv;
            OP_SRA: return 32'(sa >>> sh);
            OP_SLL: return av << sh;
            default: return av >> sh;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] op, input logic [31:0] bv);
`ifdef ALU_MC_BARREL_SHIFT_EN
        return 1 + 0 * int'(op) + 0 * int'(bv[0]);
`else
        if (op == OP_SRA || op == OP_SLL || op == OP_SRL) return 1 + int'(bv % 32);
        return 1;
`endif
    endfunction

    // Issues one request from a negedge, measures latency, checks result,
    // holds backpressure for 'hold' cycles and optionally releases the result.
    task automatic applyStimulus(input logic [2:0] op, input logic sb, input logic cu,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input int hold, input bit releaseAfter);
        logic [31:0] expRes;
        int expLat, lat, n;
        expRes = refModel(op, sb, cu, av, bv);
        expLat = refLatency(op, bv);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("readyBeforeIssue", {31'd0, in_ready}, 32'd1);
        in_valid     = 1'b1;
        ALUControl   = op;
        sub          = sb;
        cmp_unsigned = cu;
        a            = av;
        b            = bv;
        out_ready    = 1'b0;
        @(negedge clk);
        in_valid   = 1'b0;
        a          = $urandom;
        b          = $urandom;
        ALUControl = 3'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            checkOutput("readyDuringShift", {31'd0, in_ready}, 32'd0);
            checkOutput("busyDuringShift", {31'd0, busy}, 32'd1);
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("result", result, expRes);
        checkOutput("zero", {31'd0, zero}, {31'd0, expRes == 32'd0});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("holdValid", {31'd0, out_valid}, 32'd1);
            checkOutput("holdResult", result, expRes);
            checkOutput("holdZero", {31'd0, zero}, {31'd0, expRes == 32'd0});
            checkOutput("holdReady", {31'd0, in_ready}, 32'd0);
        end
        if (releaseAfter) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            checkOutput("releaseValid", {31'd0, out_valid}, 32'd0);
            checkOutput("releaseBusy", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b1;
        in_valid = 1'b0;
        ALUControl = OP_SUM;
        sub = 1'b0;
        cmp_unsigned = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetValid", {31'd0, out_valid}, 32'd0);
        checkOutput("resetResult", result, 32'd0);
        checkOutput("resetZero", {31'd0, zero}, 32'd0);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetReady", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(OP_SUM, 1'b1, 1'b0, 32'd5, 32'd3, 0, 1'b1);
        applyStimulus(OP_SUM, 1'b1, 1'b0, 32'd7, 32'd7, 0, 1'b1);
        applyStimulus(OP_SLT, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
        applyStimulus(OP_SLT, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
        applyStimulus(OP_SLL, 1'b0, 1'b0, 32'd1, 32'd5, 0, 1'b1);
        applyStimulus(OP_SRA, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 0, 1'b1);
        applyStimulus(OP_SRL, 1'b0, 1'b0, 32'h8000_0000, 32'd31, 0, 1'b1);
        applyStimulus(OP_SLL, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0020, 0, 1'b1);
        applyStimulus(OP_SLL, 1'b0, 1'b0, 32'd1, 32'd31, 0, 1'b1);

        // Backpressure then back-to-back issue of xor from DONE.
        applyStimulus(OP_AND, 1'b0, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 4, 1'b0);
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        ALUControl = OP_XOR;
        a          = 32'h0000_00F0;
        b          = 32'h0000_00FF;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2bValid", {31'd0, out_valid}, 32'd1);
        checkOutput("b2bResult", result, 32'h0000_000F);
        checkOutput("b2bZero", {31'd0, zero}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("b2bRelease", {31'd0, out_valid}, 32'd0);

        // Reset during the third shift cycle of sll by 10.
        in_valid   = 1'b1;
        ALUControl = OP_SLL;
        a          = 32'd1;
        b          = 32'd10;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortValid", {31'd0, out_valid}, 32'd0);
        checkOutput("abortResult", result, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortReady", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("abortNoValid", {31'd0, out_valid}, 32'd0);
        end
        applyStimulus(OP_SUM, 1'b0, 1'b0, 32'd1, 32'd1, 0, 1'b1);

        $display("[TB] randomized traffic");
        for (int t = 0; t < 150; t++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 4) == 0) ra = 32'd0;
            applyStimulus(rop, 1'($urandom), 1'($urandom), ra, rb, $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc_exec.md
Name: alu_mc_exec

Overview:
- Multi-cycle integer execute unit. It is the consumer of the ALU control decoder's outputs: it takes ALUControl[2:0], sub and two operands, and returns a registered result and zero flag.
- Sits between the decode/operand-fetch stage and writeback/branch logic.
- Uses a valid/ready handshake on both sides.
- Shifts run bit-serially (one bit per cycle) to save area, unless the barrel-shift option is compiled in.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- ALUControl  input  3  operation: 000 sum, 001 slt, 010 and, 011 or, 100 xor, 101 sra, 110 sll, 111 srl.
- sub  input  1  sum: 1 = a-b, 0 = a+b. Ignored for all other ops.
- cmp_unsigned  input  1  slt only: 1 = unsigned compare (SLTU/SLTIU).
- a  input  XLEN  operand A.
- b  input  XLEN  operand B. Shifts use b[SHAMT_W-1:0] only.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- result  output  XLEN  registered result.
- zero  output  1  result == 0, registered with result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, out_valid=0, result=0, zero=0 (result is 0 here, so the flag is deliberately not derived from it during reset), busy=0, shift counter=0. Reset overrides everything.
- Reset mid-shift: aborts the operation; no out_valid is produced for the aborted request.
- FSM states: IDLE, SHIFT, DONE.
- Accept condition: in_valid && in_ready, where in_ready = (state==IDLE) || (state==DONE && out_ready). This allows back-to-back issue.
- Non-shift ops, on accept:
  - compute combinationally and register into result/zero;
  - state -> DONE, so out_valid=1 on the next cycle (latency 1).
- sum: a + (sub ? ~b : b) + sub, modulo 2^XLEN. Carry is discarded.
- slt: result = {XLEN-1 zeros, lt}.
  - lt is a signed compare, or unsigned when cmp_unsigned=1.
  - Independent of sub (the decoder drives sub=1 for slt; the value is don't-care here).
- and/or/xor: bitwise.
- Shift ops, on accept:
  - load the shift register with a;
  - load counter k=b[SHAMT_W-1:0] and latch the op.
  - k==0: state -> DONE with result=a (latency 1).
  - k>0: state -> SHIFT. Each SHIFT cycle shifts one position and decrements the counter; when the counter reaches 1, the final shift is applied and state -> DONE. out_valid asserts at accept+1+k.
  - sll fills with 0; srl fills with 0; sra replicates bit XLEN-1.
- During SHIFT: in_ready=0, out_valid=0. result holds its previous value until DONE.
- DONE:
  - out_valid=1; result/zero are stable while out_valid && !out_ready.
  - out_ready=1 with no new accept -> IDLE, out_valid=0 next cycle.
  - out_ready=1 with a simultaneous accept -> the new request is processed exactly as from IDLE (no bubble for non-shift ops).
- Unknown/X on ALUControl while accepted: result undefined, but the FSM still advances as a non-shift op. No lockup.
- Inputs are sampled only on accept; changes at other times are ignored.

Optional Feature:
- Macro ALU_MC_BARREL_SHIFT_EN.
- Defined: shifts compute in one cycle with a barrel shifter, the SHIFT state is never entered, and all ops have latency 1.
- Undefined: bit-serial shift as above, latency 1+shamt.
- The interface is identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - ALUControl encodings as localparams ALU_SUM, ALU_SLT, ALU_AND, ALU_OR, ALU_XOR, ALU_SRA, ALU_SLL, ALU_SRL;
  - FSM state encoding;
  - XLEN default.
- One sub-module, alu_serial_shifter, owns the shift register and counter.
  - Interface: load, op, shamt, data_in → data_out, last.
  - Replaced by a combinational barrel shift under ALU_MC_BARREL_SHIFT_EN.

Test Plan:
- sum: a=5, b=3, sub=1 → result=2, zero=0, out_valid one cycle after accept. a=7, b=7, sub=1 → result=0, zero=1.
- slt: a=0xFFFFFFFF, b=1; cmp_unsigned=0 → result=1; cmp_unsigned=1 → result=0.
- sll: a=1, b=5 → in_ready=0 for 5 cycles, result=0x20 at accept+6. sra a=0x80000000, b=31 → 0xFFFFFFFF. srl same inputs → 1. shamt=0 → result=a at accept+1.
- Backpressure: hold out_ready=0 for 4 cycles after DONE → result/zero stable, in_ready=0. Then out_ready=1 with in_valid=1 (xor 0xF0^0xFF) → next cycle result=0x0F, no bubble.
- Reset: assert rst during the 3rd SHIFT cycle of sll by 10 → next cycle state IDLE, out_valid=0, result=0. The following add 1+1 returns 2.
- Build with ALU_MC_BARREL_SHIFT_EN: sll a=1, b=31 → result=0x80000000 at accept+1, busy never observed in SHIFT.
